pipe_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage cached core.
- Generates the write enables and flushes for the PC and for the IF/ID, ID/EX, EX/M and M/WB pipeline registers.
- Inputs it resolves: I-cache and D-cache miss stalls, load-use hazards, taken branches and HALT drain.
- Owns the RUN/DRAIN/HALTED sequencing and one deferred-redirect flag.

---
 rtl/pipe_ctrl_pkg.sv | 39 +++
 rtl/pipe_stall_ctrl_sat_counter.sv | 32 +++
 rtl/pipe_stall_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and pipe registers.
// Build option: STALL_PERF_CNT_EN adds stall performance counters.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } ctrl_state_e;

  // Register control bundle, packed MSB first.
  typedef struct packed {
    logic pc_wen;
    logic fd_wen;
    logic dx_wen;
    logic xm_wen;
    logic mw_wen;
    logic fd_flush;
    logic dx_flush;
  } pipe_ctrl_t;

  // NOP/bubble encodings loaded by the pipe registers on a flush.
  localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
  localparam logic [31:0] BUBBLE_PC   = 32'h0000_0000;
  localparam logic        BUBBLE_CTRL = 1'b0;

  // Normal advance: every register loads, nothing flushed.
  localparam pipe_ctrl_t CTRL_RUN =
    '{pc_wen: 1'b1, fd_wen: 1'b1, dx_wen: 1'b1,
      xm_wen: 1'b1, mw_wen: 1'b1,
      fd_flush: 1'b0, dx_flush: 1'b0};

  // Full freeze: no register loads.
  localparam pipe_ctrl_t CTRL_FREEZE =
    '{pc_wen: 1'b0, fd_wen: 1'b0, dx_wen: 1'b0,
      xm_wen: 1'b0, mw_wen: 1'b0,
      fd_flush: 1'b0, dx_flush: 1'b0};

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clk, rst (sync, high), inc, cnt (W bits, sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: PC/pipe-register enables and flushes, RUN/DRAIN/HALTED.
// Ports: stall/hazard/halt inputs in; *_wen, *_flush, halted out.
// Option STALL_PERF_CNT_EN adds dstall_cnt/istall_cnt (CNT_W bits).
// rst_n is a synchronous ACTIVE-HIGH reset despite its name.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic icache_stall,
  input  logic dcache_stall,
  input  logic load_use,
  input  logic branch_taken,
  input  logic halt_id,
  input  logic halt_wb,
  output logic pc_wen,
  output logic fd_wen,
  output logic dx_wen,
  output logic xm_wen,
  output logic mw_wen,
  output logic fd_flush,
  output logic dx_flush,
  output logic halted
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] istall_cnt
`endif
);

  ctrl_state_e state_q, state_d;
  logic        pend_q, pend_d;
  logic        halted_q, halted_d;
  pipe_ctrl_t  ctrl;

  // One-hot priority selects (dcache > icache > load_use > branch > none).
  logic sel_d, sel_i, sel_l, sel_b, sel_n;

  always_comb begin
    sel_d = dcache_stall;
    sel_i = !dcache_stall && icache_stall;
    sel_l = !dcache_stall && !icache_stall && load_use;
    sel_b = !dcache_stall && !icache_stall && !load_use
            && branch_taken;
    sel_n = !dcache_stall && !icache_stall && !load_use
            && !branch_taken;
  end

  always_comb begin
    ctrl     = CTRL_RUN;
    state_d  = state_q;
    pend_d   = pend_q;
    halted_d = halted_q;

    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          sel_d: ctrl = CTRL_FREEZE;
          sel_i: begin
            // A branch resolved under a fetch miss still writes the
            // target; the fetch returning afterwards is wrong-path.
            ctrl.pc_wen   = branch_taken;
            ctrl.fd_flush = 1'b1;
            if (branch_taken) pend_d = 1'b1;
          end
          sel_l: begin
            // IF/ID holds, so a pending discard waits for a load.
            ctrl.pc_wen   = 1'b0;
            ctrl.fd_wen   = 1'b0;
            ctrl.dx_flush = 1'b1;
          end
          sel_b: begin
            ctrl.fd_flush = 1'b1;
            pend_d        = 1'b0;
          end
          sel_n: begin
            if (pend_q) begin
              ctrl.fd_flush = 1'b1;
              pend_d        = 1'b0;
            end
            if (halt_id) state_d = DRAIN;
          end
          default: ctrl = CTRL_RUN;
        endcase
      end
      DRAIN: begin
        if (sel_d) begin
          ctrl = CTRL_FREEZE;
        end else begin
          // No new fetch: IF/ID takes bubbles every cycle.
          ctrl.pc_wen   = 1'b0;
          ctrl.fd_flush = 1'b1;
          ctrl.dx_flush = sel_l;
          pend_d        = 1'b0;
        end
      end
      HALTED: ctrl = CTRL_FREEZE;
      default: ctrl = CTRL_FREEZE;
    endcase

    if (halt_wb && !dcache_stall && (state_q != HALTED)) begin
      state_d  = HALTED;
      halted_d = 1'b1;
    end

    // Reset in progress: present RUN defaults regardless of inputs.
    if (rst_n) ctrl = CTRL_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= RUN;
      pend_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      halted_q <= halted_d;
    end
  end

  assign pc_wen   = ctrl.pc_wen;
  assign fd_wen   = ctrl.fd_wen;
  assign dx_wen   = ctrl.dx_wen;
  assign xm_wen   = ctrl.xm_wen;
  assign mw_wen   = ctrl.mw_wen;
  assign fd_flush = ctrl.fd_flush;
  assign dx_flush = ctrl.dx_flush;
  assign halted   = halted_q;

`ifdef STALL_PERF_CNT_EN
  logic run_ok;
  assign run_ok = (state_q != HALTED);

  sat_counter #(.W(CNT_W)) u_dstall_cnt (
    .clk (clk),
    .rst (rst_n),
    .inc (dcache_stall && run_ok),
    .cnt (dstall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_istall_cnt (
    .clk (clk),
    .rst (rst_n),
    .inc (icache_stall && !dcache_stall && run_ok),
    .cnt (istall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl.
// Counter checks are active when STALL_PERF_CNT_EN is defined.
module tb_pipe_stall_ctrl;

`ifdef STALL_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic icache_stall, dcache_stall, load_use;
  logic branch_taken, halt_id, halt_wb;
  logic pc_wen, fd_wen, dx_wen, xm_wen, mw_wen;
  logic fd_flush, dx_flush, halted;
`ifdef STALL_PERF_CNT_EN
  logic [CW-1:0] dstall_cnt, istall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .halt_id      (halt_id),
    .halt_wb      (halt_wb),
    .pc_wen       (pc_wen),
    .fd_wen       (fd_wen),
    .dx_wen       (dx_wen),
    .xm_wen       (xm_wen),
    .mw_wen       (mw_wen),
    .fd_flush     (fd_flush),
    .dx_flush     (dx_flush),
    .halted       (halted)
`ifdef STALL_PERF_CNT_EN
    ,
    .dstall_cnt   (dstall_cnt),
    .istall_cnt   (istall_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs {rst, ic, dc, lu, br, hid, hwb} at negedge, settle 1.
  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    {rst_n, icache_stall, dcache_stall, load_use,
     branch_taken, halt_id, halt_wb} = v;
    #1;
  endtask

  // Compare {pc,fd,dx,xm,mw} enables and {fd,dx} flushes.
  task automatic chk_ctl(input string tag,
                         input logic [4:0] wen,
                         input logic [1:0] fl);
    chk({tag, ".wen"},
        {27'd0, pc_wen, fd_wen, dx_wen, xm_wen, mw_wen},
        {27'd0, wen});
    chk({tag, ".fl"}, {30'd0, fd_flush, dx_flush}, {30'd0, fl});
  endtask

  task automatic chk_h(input string tag, input logic exp);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, exp});
  endtask

  initial begin
    {rst_n, icache_stall, dcache_stall, load_use,
     branch_taken, halt_id, halt_wb} = 7'b1000000;

    // Reset held two cycles; RUN defaults even with dcache_stall up.
    drive(7'b1000000);
    chk_ctl("rst0", 5'b11111, 2'b00);
    drive(7'b1010000);
    chk_ctl("rst1_dc", 5'b11111, 2'b00);

    // Release, no stalls.
    drive(7'b0000000);
    chk_ctl("run", 5'b11111, 2'b00);
    chk_h("run", 1'b0);
`ifdef STALL_PERF_CNT_EN
    chk("cnt_rst_d", 32'(dstall_cnt), 32'd0);
    chk("cnt_rst_i", 32'(istall_cnt), 32'd0);
`endif

    // dcache stall 5 cycles with load_use and branch: full freeze.
    for (int i = 0; i < 5; i++) begin
      drive(7'b0011100);
      chk_ctl($sformatf("dc%0d", i), 5'b00000, 2'b00);
    end
    drive(7'b0000000);
    chk_ctl("dc_end", 5'b11111, 2'b00);
`ifdef STALL_PERF_CNT_EN
    chk("dcnt5", 32'(dstall_cnt), 32'd5);
`endif

    // Single load-use bubble.
    drive(7'b0001000);
    chk_ctl("lu", 5'b00111, 2'b01);
    drive(7'b0000000);
    chk_ctl("lu_after", 5'b11111, 2'b00);

    // icache stall 4 cycles, branch on cycle 2 -> deferred discard.
    drive(7'b0100000);
    chk_ctl("ic1", 5'b01111, 2'b10);
    drive(7'b0100100);
    chk_ctl("ic2_br", 5'b11111, 2'b10);
    drive(7'b0100000);
    chk_ctl("ic3", 5'b01111, 2'b10);
    drive(7'b0100000);
    chk_ctl("ic4", 5'b01111, 2'b10);
    drive(7'b0000000);
    chk_ctl("ic_fall", 5'b11111, 2'b10);
    drive(7'b0000000);
    chk_ctl("ic_clr", 5'b11111, 2'b00);
`ifdef STALL_PERF_CNT_EN
    chk("icnt4", 32'(istall_cnt), 32'd4);
`endif

    // icache stall without branch: no flush on the falling cycle.
    drive(7'b0100000);
    chk_ctl("ic_nb", 5'b01111, 2'b10);
    drive(7'b0000000);
    chk_ctl("ic_nb_fall", 5'b11111, 2'b00);

    // Plain taken branch, then load_use beating branch.
    drive(7'b0000100);
    chk_ctl("br", 5'b11111, 2'b10);
    drive(7'b0001100);
    chk_ctl("lu_br", 5'b00111, 2'b01);

    // HALT in ID while load_use is up: no drain entry.
    drive(7'b0001010);
    chk_ctl("hid_lu", 5'b00111, 2'b01);
    drive(7'b0000000);
    chk_ctl("hid_lu_nx", 5'b11111, 2'b00);

    // HALT enters drain.
    drive(7'b0000010);
    chk_ctl("hid", 5'b11111, 2'b00);
    drive(7'b0000000);
    chk_ctl("drain", 5'b01111, 2'b10);
    drive(7'b0001000);
    chk_ctl("drain_lu", 5'b01111, 2'b11);
    drive(7'b0010000);
    chk_ctl("drain_dc0", 5'b00000, 2'b00);
    drive(7'b0010000);
    chk_ctl("drain_dc1", 5'b00000, 2'b00);
    // halt_wb under dcache stall must not halt.
    drive(7'b0010001);
    chk_ctl("drain_dc2", 5'b00000, 2'b00);
    drive(7'b0000001);
    chk_ctl("drain_hwb", 5'b01111, 2'b10);
    chk_h("drain_hwb", 1'b0);
`ifdef STALL_PERF_CNT_EN
    chk("dcnt8", 32'(dstall_cnt), 32'd8);
`endif

    // HALTED for 10 cycles regardless of inputs.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 7'b0011100 : 7'b0000110);
      chk_ctl($sformatf("halt%0d", i), 5'b00000, 2'b00);
      chk_h($sformatf("halt%0d", i), 1'b1);
    end
`ifdef STALL_PERF_CNT_EN
    chk("dcnt_halt", 32'(dstall_cnt), 32'd8);
`endif

    // Reset from HALTED.
    drive(7'b1000000);
    chk_ctl("rst_h", 5'b11111, 2'b00);
    drive(7'b0000000);
    chk_ctl("rst_h_run", 5'b11111, 2'b00);
    chk_h("rst_h_run", 1'b0);

    // Reset mid-icache-stall with pending redirect clears it.
    drive(7'b0100100);
    chk_ctl("ic_br_pre", 5'b11111, 2'b10);
    drive(7'b1100000);
    chk_ctl("ic_rst", 5'b11111, 2'b00);
    drive(7'b0000000);
    chk_ctl("ic_rst_clr", 5'b11111, 2'b00);

`ifdef STALL_PERF_CNT_EN
    // Saturation at 4'hF.
    for (int i = 0; i < 20; i++) drive(7'b0010000);
    drive(7'b0000000);
    chk("dsat", 32'(dstall_cnt), 32'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
